// File: rtl/zz_block_scheduler_if.sv
// Bundles the symbol request channel and the zigzag-decoder channel of the block scheduler.
// The slave modport is the scheduler side; the master modport is the entropy-decoder/zigzag side.
interface zz_block_scheduler_if;
  logic [2:0]  req_valid_in;
  logic [17:0] req_run_in;
  logic [35:0] req_value_in;
  logic [2:0]  req_ready_out;
  logic        zz_valid_out;
  logic [5:0]  zz_run_out;
  logic [11:0] zz_value_out;
  logic        zz_col_valid_in;

  modport slave (
    input  req_valid_in,
    input  req_run_in,
    input  req_value_in,
    input  zz_col_valid_in,
    output req_ready_out,
    output zz_valid_out,
    output zz_run_out,
    output zz_value_out
  );

  modport master (
    output req_valid_in,
    output req_run_in,
    output req_value_in,
    output zz_col_valid_in,
    input  req_ready_out,
    input  zz_valid_out,
    input  zz_run_out,
    input  zz_value_out
  );
endinterface

// File: rtl/zz_block_scheduler.sv
// Interleaves Y/Cb/Cr run-value symbols into one zigzag stream, one MCU block at a time; 1-cycle forward latency.
// Ready is registered and drops once MAX_INFLIGHT blocks await column drain; valid on other components is held off.
module zz_block_scheduler #(
  parameter int Y_PER_MCU    = 4,
  parameter int C_PER_MCU    = 1,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 restart_in,
  zz_block_scheduler_if.slave  bus,
  output logic [1:0]           blk_comp_out,
  output logic                 blk_done_out,
  output logic                 mcu_done_out,
  output logic                 err_out
);

  typedef enum logic [1:0] {
    ST_LUMA = 2'd0,
    ST_CB   = 2'd1,
    ST_CR   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_pos;
  logic [6:0]  w_pos_nxt;
  logic [1:0]  r_blk_cnt;
  logic [1:0]  w_blk_cnt_nxt;
  logic [1:0]  r_inflight;
  logic [1:0]  w_inflight_nxt;
  logic [2:0]  r_col_cnt;
  logic [2:0]  w_col_cnt_nxt;
  logic [2:0]  r_ready;
  logic [2:0]  w_ready_nxt;
  logic        r_zz_vld;
  logic [5:0]  r_zz_run;
  logic [5:0]  w_zz_run_nxt;
  logic [11:0] r_zz_val;
  logic [11:0] w_zz_val_nxt;
  logic        r_blk_done;
  logic        r_mcu_done;
  logic        w_mcu_done_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_acc;
  logic [5:0]  w_sel_run;
  logic [11:0] w_sel_val;
  logic [6:0]  w_sum;
  logic        w_blk_end;
  logic        w_overrun;
  logic        w_last_blk;
  logic        w_drain;
  logic        w_col_err;

  // Ready comes from a register, so acceptance never depends combinationally on valid.
  always_comb begin
    w_acc     = (|(bus.req_valid_in & r_ready)) & ~restart_in;
    w_sel_run = bus.req_run_in[5:0];
    w_sel_val = bus.req_value_in[11:0];
    case (r_state)
      ST_CB: begin
        w_sel_run = bus.req_run_in[11:6];
        w_sel_val = bus.req_value_in[23:12];
      end
      ST_CR: begin
        w_sel_run = bus.req_run_in[17:12];
        w_sel_val = bus.req_value_in[35:24];
      end
      default: ;
    endcase
    w_sum     = r_pos + {1'b0, w_sel_run} + 7'd1;
    w_blk_end = w_acc && (w_sum >= 7'd64);
    w_overrun = w_acc && (w_sum > 7'd64);
  end

  always_comb begin
    w_col_err = bus.zz_col_valid_in && (r_inflight == 2'd0);
    w_drain   = bus.zz_col_valid_in && (r_inflight != 2'd0) && (r_col_cnt == 3'd7);
    w_col_cnt_nxt = r_col_cnt;
    if (bus.zz_col_valid_in && (r_inflight != 2'd0)) begin
      w_col_cnt_nxt = r_col_cnt + 3'd1;
    end
    case ({w_blk_end, w_drain})
      2'b10:   w_inflight_nxt = r_inflight + 2'd1;
      2'b01:   w_inflight_nxt = r_inflight - 2'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
    w_err_nxt = r_err | w_overrun | w_col_err;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_blk_cnt_nxt  = r_blk_cnt;
    w_pos_nxt      = r_pos;
    w_mcu_done_nxt = 1'b0;
    w_last_blk     = 1'b0;
    case (r_state)
      ST_LUMA: w_last_blk = (r_blk_cnt == 2'(Y_PER_MCU - 1));
      ST_CB:   w_last_blk = (r_blk_cnt == 2'(C_PER_MCU - 1));
      ST_CR:   w_last_blk = (r_blk_cnt == 2'(C_PER_MCU - 1));
      default: w_last_blk = 1'b1;
    endcase
    if (restart_in) begin
      w_state_nxt   = ST_LUMA;
      w_blk_cnt_nxt = 2'd0;
      w_pos_nxt     = 7'd0;
    end else if (w_blk_end) begin
      w_pos_nxt = 7'd0;
      if (w_last_blk) begin
        w_blk_cnt_nxt = 2'd0;
        case (r_state)
          ST_LUMA: w_state_nxt = ST_CB;
          ST_CB:   w_state_nxt = ST_CR;
          default: begin
            w_state_nxt    = ST_LUMA;
            w_mcu_done_nxt = 1'b1;
          end
        endcase
      end else begin
        w_blk_cnt_nxt = r_blk_cnt + 2'd1;
      end
    end else if (w_acc) begin
      w_pos_nxt = w_sum;
    end
  end

  always_comb begin
    w_ready_nxt = 3'b000;
    if (w_inflight_nxt < 2'(MAX_INFLIGHT)) begin
      case (w_state_nxt)
        ST_CB:   w_ready_nxt = 3'b010;
        ST_CR:   w_ready_nxt = 3'b100;
        default: w_ready_nxt = 3'b001;
      endcase
    end
    w_zz_run_nxt = r_zz_run;
    w_zz_val_nxt = r_zz_val;
    if (w_acc) begin
      w_zz_run_nxt = w_sel_run;
      w_zz_val_nxt = w_sel_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_LUMA;
      r_pos      <= 7'd0;
      r_blk_cnt  <= 2'd0;
      r_inflight <= 2'd0;
      r_col_cnt  <= 3'd0;
      r_ready    <= 3'b000;
      r_zz_vld   <= 1'b0;
      r_zz_run   <= 6'd0;
      r_zz_val   <= 12'd0;
      r_blk_done <= 1'b0;
      r_mcu_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pos      <= w_pos_nxt;
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_col_cnt  <= w_col_cnt_nxt;
      r_ready    <= w_ready_nxt;
      r_zz_vld   <= w_acc;
      r_zz_run   <= w_zz_run_nxt;
      r_zz_val   <= w_zz_val_nxt;
      r_blk_done <= w_blk_end;
      r_mcu_done <= w_mcu_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.req_ready_out = r_ready;
  assign bus.zz_valid_out  = r_zz_vld;
  assign bus.zz_run_out    = r_zz_run;
  assign bus.zz_value_out  = r_zz_val;
  assign blk_comp_out      = r_state;
  assign blk_done_out      = r_blk_done;
  assign mcu_done_out      = r_mcu_done;
  assign err_out           = r_err;

endmodule

// File: tb/tb_zz_block_scheduler.sv
// Directed bench for zz_block_scheduler: MCU-index reference model checked every cycle, plus literal spot checks.
module tb_zz_block_scheduler;
  localparam int Y    = 4;
  localparam int C    = 1;
  localparam int MAXI = 2;
  localparam int TOT  = Y + 2 * C;

  logic       clk_in     = 1'b0;
  logic       rst_n_in   = 1'b1;
  logic       restart_in = 1'b0;
  logic [1:0] blk_comp_out;
  logic       blk_done_out;
  logic       mcu_done_out;
  logic       err_out;

  zz_block_scheduler_if bus();

  zz_block_scheduler #(
    .Y_PER_MCU    (Y),
    .C_PER_MCU    (C),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .restart_in   (restart_in),
    .bus          (bus),
    .blk_comp_out (blk_comp_out),
    .blk_done_out (blk_done_out),
    .mcu_done_out (mcu_done_out),
    .err_out      (err_out)
  );

  always #5 clk_in = ~clk_in;

  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;
  logic [2:0] hold_mask = 3'b000;

  // Reference model: block index within the MCU, position, blocks awaiting drain.
  int          m_pos, m_infl, m_col, m_idx;
  bit          m_live, m_err, m_zv, m_bd, m_md;
  logic [5:0]  m_run;
  logic [11:0] m_val;

  function automatic int comp_of(input int idx);
    if (idx < Y) return 0;
    if (idx < Y + C) return 1;
    return 2;
  endfunction

  function automatic logic [2:0] exp_rdy();
    if (m_live && (m_infl < MAXI)) return 3'(1 << comp_of(m_idx));
    return 3'b000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    m_pos = 0; m_infl = 0; m_col = 0; m_idx = 0;
    m_live = 0; m_err = 0; m_zv = 0; m_bd = 0; m_md = 0;
    m_run = '0; m_val = '0;
    forever begin : mdl
      int         c;
      int         run;
      int         sum;
      logic [2:0] rdy;
      bit         acc, bend, dr;
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) begin
        m_pos = 0; m_infl = 0; m_col = 0; m_idx = 0;
        m_live = 0; m_err = 0; m_zv = 0; m_bd = 0; m_md = 0;
        m_run = '0; m_val = '0;
      end else begin
        c    = comp_of(m_idx);
        rdy  = exp_rdy();
        acc  = !restart_in && bus.req_valid_in[c] && rdy[c];
        bend = 0; dr = 0; sum = 0;
        m_bd = 0; m_md = 0; m_zv = acc;
        if (acc) begin
          run   = int'(bus.req_run_in[6*c +: 6]);
          m_run = 6'(run);
          m_val = bus.req_value_in[12*c +: 12];
          sum   = m_pos + run + 1;
          if (sum >= 64) bend = 1;
          if (sum > 64) m_err = 1;
        end
        if (bus.zz_col_valid_in) begin
          if (m_infl == 0) m_err = 1;
          else if (m_col == 7) begin m_col = 0; dr = 1; end
          else m_col = m_col + 1;
        end
        m_infl = m_infl + int'(bend) - int'(dr);
        if (restart_in) begin
          m_pos = 0; m_idx = 0;
        end else if (bend) begin
          m_bd  = 1;
          m_md  = (m_idx == TOT - 1);
          m_pos = 0;
          m_idx = (m_idx + 1) % TOT;
        end else if (acc) begin
          m_pos = sum;
        end
        m_live = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (armed) begin
        chk("ready",    64'(bus.req_ready_out), 64'(exp_rdy()));
        chk("zz_valid", 64'(bus.zz_valid_out),  64'(m_zv));
        chk("zz_run",   64'(bus.zz_run_out),    64'(m_run));
        chk("zz_value", 64'(bus.zz_value_out),  64'(m_val));
        chk("blk_done", 64'(blk_done_out),      64'(m_bd));
        chk("mcu_done", 64'(mcu_done_out),      64'(m_md));
        chk("err",      64'(err_out),           64'(m_err));
        chk("blk_comp", 64'(blk_comp_out),      64'(comp_of(m_idx)));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int c, input int run, input int val);
    bit ok;
    bit s;
    ok = 0;
    bus.req_run_in[6*c +: 6]    = 6'(run);
    bus.req_value_in[12*c +: 12] = 12'(val);
    bus.req_valid_in = hold_mask | 3'(1 << c);
    for (int i = 0; i < 200; i++) begin
      s = bus.req_ready_out[c];
      @(posedge clk_in);
      #1;
      if (s) begin ok = 1; break; end
    end
    bus.req_valid_in = hold_mask;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic cols(input int n);
    bus.zz_col_valid_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
    bus.zz_col_valid_in = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},    64'(bus.req_ready_out), 64'(0));
    chk({tag, "_zz_valid"}, 64'(bus.zz_valid_out),  64'(0));
    chk({tag, "_zz_run"},   64'(bus.zz_run_out),    64'(0));
    chk({tag, "_zz_value"}, 64'(bus.zz_value_out),  64'(0));
    chk({tag, "_comp"},     64'(blk_comp_out),      64'(0));
    chk({tag, "_blk_done"}, 64'(blk_done_out),      64'(0));
    chk({tag, "_mcu_done"}, 64'(mcu_done_out),      64'(0));
    chk({tag, "_err"},      64'(err_out),           64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_comp [6];
    bit  s;
    bit  ok;
    exp_comp = '{0, 0, 0, 0, 1, 2};
    bus.req_valid_in    = 3'b000;
    bus.req_run_in      = '0;
    bus.req_value_in    = '0;
    bus.zz_col_valid_in = 1'b0;

    // reset and first ready
    #2 rst_n_in = 1'b0;
    armed = 1'b1;
    #1 chk_reset_vals("rst");
    cyc(2);
    rst_n_in = 1'b1;
    chk("rel_ready_pre", 64'(bus.req_ready_out), 64'(0));
    cyc(1);
    chk("rel_ready", 64'(bus.req_ready_out), 64'(3'b001));

    // single-symbol Y block
    send(0, 63, 5);
    chk("b1_valid", 64'(bus.zz_valid_out), 64'(1));
    chk("b1_run",   64'(bus.zz_run_out),   64'(63));
    chk("b1_value", 64'(bus.zz_value_out), 64'(5));
    chk("b1_done",  64'(blk_done_out),     64'(1));
    chk("b1_pos",   64'(m_pos),            64'(0));
    chk("b1_infl",  64'(m_infl),           64'(1));

    // inflight limit and drain
    send(0, 63, 1);
    chk("lim_ready0", 64'(bus.req_ready_out), 64'(0));
    cyc(3);
    chk("lim_ready1", 64'(bus.req_ready_out), 64'(0));
    cols(7);
    chk("lim_ready7", 64'(bus.req_ready_out), 64'(0));
    cols(1);
    chk("lim_ready8", 64'(bus.req_ready_out), 64'(3'b001));
    cols(8);
    chk("lim_infl0", 64'(m_infl), 64'(0));

    // full 4:2:0 MCU from a restart
    restart_in = 1'b1;
    cyc(1);
    restart_in = 1'b0;
    chk("mcu_start_comp", 64'(blk_comp_out), 64'(0));
    for (int b = 0; b < 6; b++) begin
      chk("mcu_comp", 64'(blk_comp_out), 64'(exp_comp[b]));
      send(exp_comp[b], 63, b + 10);
      chk("mcu_blk_done", 64'(blk_done_out), 64'(1));
      chk("mcu_done_flag", 64'(mcu_done_out), 64'(b == 5));
      cols(8);
    end
    chk("mcu_wrap_comp", 64'(blk_comp_out), 64'(0));

    // overrun from pos 60
    send(0, 59, 100);
    chk("ovr_pre_done", 64'(blk_done_out), 64'(0));
    chk("ovr_pre_err",  64'(err_out),      64'(0));
    chk("ovr_pos60",    64'(m_pos),        64'(60));
    send(0, 10, -7);
    chk("ovr_err",   64'(err_out),         64'(1));
    chk("ovr_done",  64'(blk_done_out),    64'(1));
    chk("ovr_run",   64'(bus.zz_run_out),  64'(10));
    chk("ovr_value", 64'(bus.zz_value_out), 64'(12'hFF9));
    chk("ovr_pos0",  64'(m_pos),           64'(0));
    cols(8);

    // Cb valid held through the rest of LUMA
    bus.req_run_in[11:6]    = 6'd10;
    bus.req_value_in[23:12] = 12'hFFD;
    hold_mask = 3'b010;
    bus.req_valid_in = hold_mask;
    cyc(4);
    chk("hold_ready", 64'(bus.req_ready_out), 64'(3'b001));
    chk("hold_valid", 64'(bus.zz_valid_out),  64'(0));
    send(0, 63, 1);
    cols(8);
    send(0, 63, 2);
    cols(8);
    send(0, 63, 3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      s = bus.req_ready_out[1];
      @(posedge clk_in);
      #1;
      if (s) begin ok = 1; break; end
    end
    hold_mask = 3'b000;
    bus.req_valid_in = 3'b000;
    if (!ok) chk("hold_timeout", 64'(0), 64'(1));
    chk("cb_valid", 64'(bus.zz_valid_out), 64'(1));
    chk("cb_run",   64'(bus.zz_run_out),   64'(10));
    chk("cb_value", 64'(bus.zz_value_out), 64'(12'hFFD));
    chk("cb_comp",  64'(blk_comp_out),     64'(1));
    chk("cb_pos",   64'(m_pos),            64'(11));
    chk("cb_infl",  64'(m_infl),           64'(1));

    // restart mid-Cb with a same-cycle Cb symbol offered
    bus.req_valid_in = 3'b010;
    restart_in = 1'b1;
    cyc(1);
    restart_in = 1'b0;
    bus.req_valid_in = 3'b000;
    chk("rs_valid", 64'(bus.zz_valid_out), 64'(0));
    chk("rs_comp",  64'(blk_comp_out),     64'(0));
    chk("rs_ready", 64'(bus.req_ready_out), 64'(3'b001));
    chk("rs_pos",   64'(m_pos),            64'(0));
    chk("rs_infl",  64'(m_infl),           64'(1));

    // reset mid-block
    send(0, 5, 33);
    #3 rst_n_in = 1'b0;
    #1 chk_reset_vals("mid");
    cyc(2);
    rst_n_in = 1'b1;
    chk("mid_ready_pre", 64'(bus.req_ready_out), 64'(0));
    cyc(1);
    chk("mid_ready", 64'(bus.req_ready_out), 64'(3'b001));
    send(0, 63, 9);
    chk("mid_fresh_done", 64'(blk_done_out), 64'(1));
    chk("mid_fresh_err",  64'(err_out),      64'(0));
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
